// File: rtl/sccb_responder.sv
// sccb_responder: SCCB camera-side responder with a 256x8 register file, bus write events and a fabric read port.
module sccb_responder #(
  parameter logic [7:0] WR_ID       = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       wr_strobe_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUBADDR, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP
  } state_e;
  localparam logic [7:0] RD_ID = WR_ID | 8'h01;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d, ptr_q, ptr_d;
  logic [7:0]             wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_data_q;
  logic                   oe_q, oe_d, rw_q, rw_d, busy_q, busy_d, strobe_q, strobe_d;
  logic [7:0]             regs_q [256];
  logic                   scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0]             byte_in, rd_byte;
  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & ~sda_s & sda_prev_q;
  assign stop     = scl_s & sda_s & ~sda_prev_q;
  assign byte_in  = {shift_q[6:0], sda_s};
  assign rd_byte  = regs_q[ptr_q];
  // Synchronizers idle high so reset release never fakes a START.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ID;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ID, SUBADDR, WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = state_q == ID ? ((byte_in == WR_ID || byte_in == RD_ID) ? ID_ACK : WAIT_STOP) :
                      state_q == SUBADDR ? SUB_ACK : WDATA_ACK;
            if (state_q == ID) rw_d = byte_in == RD_ID;
            if (state_q == SUBADDR) ptr_d = byte_in;
            if (state_q == WDATA) begin
              strobe_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
            end
          end
        end
        // First fall drives the ACK low, second fall releases it (or presents read bit 7).
        ID_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
          oe_d = ~oe_q;
          if (oe_q) begin
            state_d = state_q == SUB_ACK ? WDATA : state_q == WDATA_ACK ? WAIT_STOP :
                      rw_q ? RDATA : SUBADDR;
            if (state_q == ID_ACK && rw_q) begin
              oe_d    = ~rd_byte[7];
              shift_d = {rd_byte[6:0], 1'b0};
            end
          end
        end
        RDATA: if (scl_fall) begin
          oe_d    = cnt_q == 3'd7 ? 1'b0 : ~shift_q[7];
          state_d = cnt_q == 3'd7 ? RD_NA : RDATA;
          shift_d = {shift_q[6:0], 1'b0};
          cnt_d   = cnt_q + 3'd1;
        end
        RD_NA: if (scl_rise) state_d = WAIT_STOP;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      oe_q      <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= regs_q[rd_addr_i];
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
    end else if (strobe_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end
  assign sda_io      = oe_q ? 1'b0 : 1'bz;
  assign rd_data_o   = rd_data_q;
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB (two-wire camera control) responder that emulates the register-programming port of an OV7670-class image sensor. It sits on the camera side of the `sda_io`/`scl_o` bus driven by `camera_controller`, so the controller's configuration sequences can be checked in closed loop in simulation or on-board. Writes are stored in an internal 256 x 8 register file, exposed to fabric through a write-event port and a read port. Reads return register contents over the bus.

## Interface
Parameters:
- `WR_ID`, 8'h42: device write address (the read address is `WR_ID | 1`).
- `SYNC_STAGES`, 2: synchronizer depth on `scl_i` and on the `sda_io` input.

Ports:
- `clk_i`  in  1  system clock; must be at least 20x the SCL frequency.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `scl_i`  in  1  SCCB clock from the master.
- `sda_io`  inout  1  SCCB data; open-drain, this block drives only 1'b0 or 1'bz.
- `rd_addr_i`  in  8  fabric read address.
- `rd_data_o`  out  8  register contents at `rd_addr_i`; registered, 1-cycle latency.
- `wr_strobe_o`  out  1  one-cycle pulse when a bus write commits.
- `wr_addr_o`  out  8  sub-address of the last committed write.
- `wr_data_o`  out  8  data of the last committed write.
- `busy_o`  out  1  high from a detected START to a detected STOP.

## Operation
- Input conditioning:
  - `scl_i` and the `sda_io` input each pass through `SYNC_STAGES` flops.
  - Edge detect on the synchronized signals.
  - START is a synchronized SDA fall while synchronized SCL is high; STOP is an SDA rise while SCL is high.
  - Data bits are sampled on the synchronized SCL rise, MSB first.
- FSM states: IDLE, ID, ID_ACK, SUBADDR, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP.
  - IDLE: on START, go to ID with the bit counter cleared.
  - ID: after 8 bits:
    - byte equals `WR_ID` -> ID_ACK, then SUBADDR.
    - byte equals `WR_ID|1` -> ID_ACK, then RDATA.
    - any other byte -> WAIT_STOP; SDA is never driven.
  - SUBADDR: after 8 bits, latch the sub-address pointer, then SUB_ACK -> WDATA.
  - WDATA: after 8 bits, write the register, update `wr_addr_o`/`wr_data_o` and pulse `wr_strobe_o`, then WDATA_ACK -> WAIT_STOP.
    - Further bytes in the same transaction are ignored; there is no auto-increment.
  - RDATA: shift out the register at the pointer MSB first, then RD_NA.
    - RD_NA: the master's 9th bit is ignored; go to WAIT_STOP.
  - A two-phase write (ID + sub-address, then STOP) only sets the pointer; this is the standard SCCB read setup.
  - Any START in any state restarts at ID (repeated start). Any STOP in any state goes to IDLE and releases SDA.
- ACK phases:
  - Drive SDA low from the SCL fall that follows the 8th bit's rise.
  - Release SDA at the next SCL fall.
- Register file: 256 x 8, all locations reset to 8'h00. The only writer is the bus. `rd_data_o` is registered from `rd_addr_i`.

## Timing
- SDA drive changes occur exactly `SYNC_STAGES`+1 `clk_i` cycles after the raw `scl_i` fall (3 cycles at default). They never occur while SCL is high.
- `wr_strobe_o` pulses for 1 cycle, `SYNC_STAGES`+1 cycles after the raw SCL rise that samples data bit 0. `wr_addr_o`/`wr_data_o` become valid in that same cycle.
- Read data bit 7 is driven at the SCL fall that ends ID_ACK (ACK release and bit 7 occur in the same cycle). Each following bit is driven at each subsequent SCL fall. SDA is released at the fall after bit 0.
- `busy_o` rises `SYNC_STAGES`+1 cycles after the raw START and falls `SYNC_STAGES`+1 cycles after the raw STOP.
- `rd_data_o` reflects a bus write on the cycle after `wr_strobe_o` when `rd_addr_i` matches.
- Reset (asynchronous, at any time, including mid-byte):
  - Effects: FSM -> IDLE, SDA -> 1'bz, `wr_strobe_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `rd_data_o`=0, pointer=0, all registers 0.
  - After release, nothing is acknowledged until a fresh START.

## Test plan
- Three-phase write ID 8'h42, sub 8'h12, data 8'h80 at 100 kHz SCL, `clk_i` 100 MHz -> three ACK lows; one `wr_strobe_o` pulse with `wr_addr_o`=8'h12, `wr_data_o`=8'h80; `rd_addr_i`=8'h12 gives `rd_data_o`=8'h80.
- Write 8'h3A <= 8'h04, then two-phase write ID 8'h42 sub 8'h3A, STOP, then ID 8'h43 -> ACK after ID, then SDA bits 0,0,0,0,0,1,0,0; SDA released after bit 0.
- ID 8'h60, sub 8'h12, data 8'hFF -> SDA never driven; no `wr_strobe_o`; register 8'h12 unchanged.
- START, ID 8'h42, 4 bits of sub-address, repeated START, full write 8'h11 <= 8'h55 -> only 8'h11 is written; one strobe.
- STOP after 5 data bits of a write to 8'h20 -> no strobe; register 8'h20 stays 8'h00; `busy_o` low.
- `rst_n_i` asserted while SDA is driven low during an ACK -> SDA immediately 1'bz, all outputs 0, register file cleared; the next valid write succeeds.
